// File: rtl/node_mac_sequencer.sv
// Serial multiply-accumulate controller for one fully-connected neuron node.
// Shares one external float multiplier and adder across N_INPUTS terms, then applies ReLU.
module node_mac_sequencer #(
    parameter int N_INPUTS = 15,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic [31:0]      a_data,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [IDX_W-1:0] w_idx,
    input  logic [31:0]      w_data,
    output logic [31:0]      mul_x,
    output logic [31:0]      mul_y,
    input  logic [31:0]      mul_z,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic [31:0]      res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       state_dbg
);

    // Handshakes: a word moves on a channel only in a cycle where both valid and ready are high;
    // a producer holds valid and data stable until that cycle.
    typedef enum logic [1:0] {IDLE, LOAD, ACCUM, OUT} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_INPUTS - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] cnt, cnt_nx;
    logic [31:0]      acc, acc_nx;
    logic [31:0]      prod, prod_nx;
    logic [31:0]      res_nx;

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            prod     <= '0;
            res_data <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            acc      <= acc_nx;
            prod     <= prod_nx;
            res_data <= res_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_nx    = acc;
        prod_nx   = prod;
        res_nx    = res_data;
        busy      = 1'b1;
        a_ready   = 1'b0;
        res_valid = 1'b0;
        w_idx     = '0;
        mul_x     = '0;
        mul_y     = '0;
        add_a     = '0;
        add_b     = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = LOAD;
                    cnt_nx   = '0;
                end
            end
            LOAD: begin
                a_ready = 1'b1;
                w_idx   = cnt;
                mul_x   = a_data;
                mul_y   = w_data;
                if (a_valid) begin
                    prod_nx  = mul_z;
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                // First term loads the accumulator directly, so the adder stays idle for it.
                if (cnt == '0) begin
                    acc_nx = prod;
                end else begin
                    add_a  = acc;
                    add_b  = prod;
                    acc_nx = add_sum;
                end
                if (cnt == LAST) begin
                    state_nx = OUT;
                    res_nx   = acc_nx[31] ? 32'h0000_0000 : acc_nx;
                end else begin
                    cnt_nx   = cnt + 1'b1;
                    state_nx = LOAD;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                    res_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_node_mac_sequencer.sv
// Bench for node_mac_sequencer: behavioural float units and ROM around a 15-input and a 1-input node.
module tb_node_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_pass = 0;
    int          n_checks = 0;

    logic        start, busy, a_valid, a_ready, res_valid, res_ready;
    logic [31:0] a_data, w_data, mul_x, mul_y, mul_z, add_a, add_b, add_sum, res_data;
    logic [3:0]  w_idx;
    logic [1:0]  state_dbg;
    logic [31:0] wrom [16];

    logic        start1, busy1, a_valid1, a_ready1, res_valid1, res_ready1;
    logic [31:0] a_data1, w1, mul_x1, mul_y1, mul_z1, add_a1, add_b1, add_sum1, res_data1;
    logic [0:0]  w_idx1;
    logic [1:0]  state_dbg1;

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        real v;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        v = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic   s;
        real    v;
        int     e;
        longint m;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        v = s ? -r : r;
        e = 0;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        m = longint'((v - 1.0) * 8388608.0);
        return {s, 8'(e + 127), m[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        if (x[30:0] == 31'd0 || y[30:0] == 31'd0) return {x[31] ^ y[31], 31'd0};
        return r2f(f2r(x) * f2r(y));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return r2f(f2r(x) + f2r(y));
    endfunction

    assign w_data   = wrom[w_idx];
    assign mul_z    = fmul(mul_x, mul_y);
    assign add_sum  = fadd(add_a, add_b);
    assign mul_z1   = fmul(mul_x1, mul_y1);
    assign add_sum1 = fadd(add_a1, add_b1);

    node_mac_sequencer #(.N_INPUTS(15), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .w_idx(w_idx), .w_data(w_data),
        .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .state_dbg(state_dbg)
    );

    node_mac_sequencer #(.N_INPUTS(1), .IDX_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1),
        .a_data(a_data1), .a_valid(a_valid1), .a_ready(a_ready1),
        .w_idx(w_idx1), .w_data(w1),
        .mul_x(mul_x1), .mul_y(mul_y1), .mul_z(mul_z1),
        .add_a(add_a1), .add_b(add_b1), .add_sum(add_sum1),
        .res_data(res_data1), .res_valid(res_valid1), .res_ready(res_ready1),
        .state_dbg(state_dbg1)
    );

    typedef struct {
        logic [31:0] a_val;
        logic [31:0] w_val;
        bit          w_ramp;
        int          stall_idx;
        int          stall_len;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic run_vec(input vec_t v, input logic rdy, output int lat, output logic [31:0] res);
        int k, stall_left;
        logic acc_now;
        for (int i = 0; i < 16; i++) wrom[i] = v.w_ramp ? r2f(real'(i)) : v.w_val;
        @(negedge clk);
        start = 1'b1;
        res_ready = rdy;
        a_data = v.a_val;
        k = 0;
        stall_left = v.stall_len;
        lat = 0;
        while (!res_valid && lat < 200) begin
            if (a_ready && k == v.stall_idx && stall_left > 0) begin
                a_valid = 1'b0;
                stall_left--;
                check("stall_w_idx", 32'(w_idx), 32'(v.stall_idx));
            end else begin
                a_valid = 1'b1;
            end
            acc_now = a_ready & a_valid;
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (acc_now) k++;
            if (!res_valid) @(negedge clk);
        end
        a_valid = 1'b0;
        res = res_data;
    endtask

    task automatic run1(input logic [31:0] a, input logic [31:0] w, input logic [31:0] exp);
        int lat;
        logic addnz;
        @(negedge clk);
        start1 = 1'b1;
        a_data1 = a;
        w1 = w;
        a_valid1 = 1'b1;
        res_ready1 = 1'b1;
        lat = 0;
        addnz = 1'b0;
        while (!res_valid1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            start1 = 1'b0;
            addnz = addnz | (|{add_a1, add_b1});
        end
        a_valid1 = 1'b0;
        check("n1_latency", 32'(lat), 32'd3);
        check("n1_res_data", res_data1, exp);
        check("n1_adder_idle", 32'(addnz), 32'd0);
        @(posedge clk); #1;
        check("n1_idle_after", {30'd0, res_valid1, busy1}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] res, held;

        start = 0; a_valid = 0; a_data = 0; res_ready = 1;
        start1 = 0; a_valid1 = 0; a_data1 = 0; res_ready1 = 1; w1 = 0;
        for (int i = 0; i < 16; i++) wrom[i] = 32'h0;

        vecs[0] = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 0, 0, 32'h4170_0000, 31};
        vecs[1] = '{32'hBF80_0000, 32'h3F80_0000, 1'b0, 0, 0, 32'h0000_0000, 31};
        vecs[2] = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 6, 3, 32'h4170_0000, 34};
        vecs[3] = '{32'h4000_0000, 32'h3F00_0000, 1'b0, 0, 0, 32'h4170_0000, 31};
        vecs[4] = '{32'h3F00_0000, 32'hC000_0000, 1'b0, 0, 0, 32'h0000_0000, 31};
        vecs[5] = '{32'h3F80_0000, 32'h0000_0000, 1'b1, 0, 0, 32'h42D2_0000, 31};
        vecs[6] = '{32'hBF80_0000, 32'h0000_0000, 1'b1, 0, 0, 32'h0000_0000, 31};

        #2 rst = 1'b1;
        #1;
        check("reset_ctrl", {28'd0, busy, a_ready, res_valid, busy1}, 32'd0);
        check("reset_res_data", res_data, 32'd0);
        check("reset_w_idx", {27'd0, w_idx, w_idx1}, 32'd0);
        check("reset_mul", mul_x | mul_y, 32'd0);
        check("reset_add", add_a | add_b, 32'd0);
        check("reset_state", {28'd0, state_dbg, state_dbg1}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], 1'b1, lat, res);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_res_data", i), res, vecs[i].exp_res);
            @(posedge clk); #1;
            check($sformatf("vec%0d_idle_after", i), {30'd0, res_valid, busy}, 32'd0);
        end

        // Consumer stalls in OUT; a start pulse during the stall must be dropped.
        run_vec(vecs[0], 1'b0, lat, held);
        check("bp_res_data", held, 32'h4170_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) start = (i == 2);
            @(posedge clk); #1;
            check("bp_hold_data", res_data, 32'h4170_0000);
            check("bp_hold_flags", {30'd0, res_valid, busy}, 32'd3);
        end
        @(negedge clk);
        start = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bp_release", {30'd0, res_valid, busy}, 32'd0);
        @(posedge clk); #1;
        check("bp_start_ignored", {30'd0, a_ready, busy}, 32'd0);

        // Asynchronous reset while element 9 is being loaded.
        for (int i = 0; i < 16; i++) wrom[i] = 32'h3F80_0000;
        @(negedge clk);
        start = 1'b1;
        a_data = 32'h3F80_0000;
        a_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end while (!(a_ready && w_idx == 4'd8) && lat < 100);
        check("abort_reach_elem9", 32'(w_idx), 32'd8);
        #2 rst = 1'b1;
        #1;
        check("abort_ctrl", {29'd0, busy, a_ready, res_valid}, 32'd0);
        check("abort_outs", {28'd0, w_idx} | mul_x | mul_y | res_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        a_valid = 1'b0;
        run_vec('{32'h4000_0000, 32'h3F80_0000, 1'b0, 0, 0, 32'h41F0_0000, 31}, 1'b1, lat, res);
        check("post_abort_latency", 32'(lat), 32'd31);
        check("post_abort_res", res, 32'h41F0_0000);
        @(posedge clk); #1;

        // Single-input node: adder never engaged, sign bit alone drives ReLU.
        run1(32'hC000_0000, 32'h3F00_0000, 32'h0000_0000);
        run1(32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000);
        run1(32'h8000_0000, 32'h3F80_0000, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
